// File: rtl/lockout_timer.sv
// lockout_timer: penalty stage that follows the combination lock.
// When lock_trig is sampled high with en=1 the block shows DENIED for
// DENY_SECS seconds, then counts COUNT_START..0 on the two rightmost digits.
// It finishes with a single-cycle done pulse that lets the lock restore its
// attempt count. Outputs are registered from the next-state values, so they
// follow the state register with no extra cycle of latency.
module lockout_timer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DENY_SECS   = 5,
  parameter int COUNT_START = 55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       lock_trig,
  output logic       lockout,
  output logic       done,
  output logic [6:0] led5,
  output logic [6:0] led4,
  output logic [6:0] led3,
  output logic [6:0] led2,
  output logic [6:0] led1,
  output logic [6:0] led0
);

  localparam int             PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [7:0]     SEC_INIT = 8'(DENY_SECS);
  localparam logic [6:0]     VAL_INIT = 7'(COUNT_START);
  localparam logic [6:0]     SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DENIED = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      sec_q, sec_d;
  logic [6:0]      value_q, value_d;
  logic            tick;

  logic            lockout_q, lockout_d;
  logic            done_q, done_d;
  logic [5:0][6:0] led_q, led_d;

  // Active-low 7-segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] seg7(input logic [6:0] d);
    logic [6:0] s;
    case (d)
      7'd0:    s = 7'h40;
      7'd1:    s = 7'h79;
      7'd2:    s = 7'h24;
      7'd3:    s = 7'h30;
      7'd4:    s = 7'h19;
      7'd5:    s = 7'h12;
      7'd6:    s = 7'h02;
      7'd7:    s = 7'h78;
      7'd8:    s = 7'h00;
      7'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One-second tick: the prescaler has reached its last count.
  assign tick = (pre_q == PRE_MAX);

  // Next-state logic: phase sequencing, prescaler, second and countdown counters.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    value_d = value_q;
    case (state_q)
      S_IDLE: begin
        // Prescaler parked at zero so DENIED starts on a whole second.
        pre_d = '0;
        if (lock_trig && en) begin
          state_d = S_DENIED;
          sec_d   = SEC_INIT;
        end
      end
      S_DENIED: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          sec_d = sec_q - 8'd1;
          if (sec_q == 8'd1) begin
            state_d = S_COUNT;
            value_d = VAL_INIT;
          end
        end
      end
      S_COUNT: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (value_q == 7'd0) begin
            state_d = S_DONE;
          end else begin
            value_d = value_q - 7'd1;
          end
        end
      end
      S_DONE: begin
        // Single cycle; lock_trig is not looked at here, so a held
        // trigger re-enters DENIED only after one IDLE cycle.
        pre_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        pre_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    lockout_d = 1'b0;
    done_d    = 1'b0;
    led_d     = {6{SEG_BLANK}};
    case (state_d)
      S_DENIED: begin
        lockout_d = 1'b1;
        // D E N I E D, leftmost first.
        led_d     = {7'h21, 7'h06, 7'h48, 7'h79, 7'h06, 7'h21};
      end
      S_COUNT, S_DONE: begin
        lockout_d = 1'b1;
        done_d    = (state_d == S_DONE);
        // Leading zero is intentionally shown on the tens digit.
        led_d[1]  = seg7(value_d / 7'd10);
        led_d[0]  = seg7(value_d % 7'd10);
      end
      default: begin
        lockout_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything, so no done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      sec_q     <= 8'd0;
      value_q   <= 7'd0;
      lockout_q <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= {6{SEG_BLANK}};
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      value_q   <= value_d;
      lockout_q <= lockout_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign lockout = lockout_q;
  assign done    = done_q;
  assign led5    = led_q[5];
  assign led4    = led_q[4];
  assign led3    = led_q[3];
  assign led2    = led_q[2];
  assign led1    = led_q[1];
  assign led0    = led_q[0];

endmodule

// File: tb/tb_lockout_timer.sv
// Testbench for lockout_timer. Two instances share the stimulus:
// A uses CLK_HZ=10, DENY_SECS=5, COUNT_START=55; B uses CLK_HZ=10,
// DENY_SECS=1, COUNT_START=0. Every cycle both are compared against a
// phase-arithmetic reference model; table vectors and directed sequences
// add explicit checks at the interesting cycles.
module tb_lockout_timer;

  localparam int HZ_A = 10, DS_A = 5, CS_A = 55;
  localparam int HZ_B = 10, DS_B = 1, CS_B = 0;

  localparam logic [6:0]  DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [41:0] BLANK6 = {6{7'h7F}};
  localparam logic [41:0] DENIED6 = {7'h21, 7'h06, 7'h48, 7'h79, 7'h06, 7'h21};

  logic clk = 1'b0;
  logic rst, en, lock_trig;
  logic lockout_a, done_a, lockout_b, done_b;
  logic [6:0] l5a, l4a, l3a, l2a, l1a, l0a;
  logic [6:0] l5b, l4b, l3b, l2b, l1b, l0b;
  logic [43:0] got_a, got_b;

  assign got_a = {lockout_a, done_a, l5a, l4a, l3a, l2a, l1a, l0a};
  assign got_b = {lockout_b, done_b, l5b, l4b, l3b, l2b, l1b, l0b};

  always #5 clk = ~clk;

  lockout_timer #(.CLK_HZ(HZ_A), .DENY_SECS(DS_A), .COUNT_START(CS_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .lock_trig(lock_trig),
    .lockout(lockout_a), .done(done_a),
    .led5(l5a), .led4(l4a), .led3(l3a), .led2(l2a), .led1(l1a), .led0(l0a)
  );

  lockout_timer #(.CLK_HZ(HZ_B), .DENY_SECS(DS_B), .COUNT_START(CS_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .lock_trig(lock_trig),
    .lockout(lockout_b), .done(done_b),
    .led5(l5b), .led4(l4b), .led3(l3b), .led2(l2b), .led1(l1b), .led0(l0b)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  started_a = 0, started_b = 0;
  int  start_a = 0, start_b = 0;

  // Expected {lockout, done, led5..led0} for cycle c of a run triggered in cycle start.
  function automatic logic [43:0] model(input int hz, input int ds, input int cs,
                                        input bit started, input int start, input int c);
    int k, total, v;
    bit is_done;
    total = (ds + cs + 1) * hz;
    k = c - start;
    if (!started || k < 1 || k > total + 1) return {2'b00, BLANK6};
    if (k <= ds * hz) return {2'b10, DENIED6};
    is_done = (k == total + 1);
    v = is_done ? 0 : cs - (k - ds * hz - 1) / hz;
    return {1'b1, is_done, {4{7'h7F}}, DIG[v / 10], DIG[v % 10]};
  endfunction

  function automatic bit is_idle(input int hz, input int ds, input int cs,
                                 input bit started, input int start, input int c);
    return !started || (c - start >= (ds + cs + 1) * hz + 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Drive inputs for cycle cyc, advance one edge, update the model, compare both DUTs.
  task automatic step(input bit r, input bit e, input bit t);
    rst = r; en = e; lock_trig = t;
    @(posedge clk);
    if (r) begin
      started_a = 0;
      started_b = 0;
    end else begin
      if (e && t && is_idle(HZ_A, DS_A, CS_A, started_a, start_a, cyc)) begin
        started_a = 1; start_a = cyc;
      end
      if (e && t && is_idle(HZ_B, DS_B, CS_B, started_b, start_b, cyc)) begin
        started_b = 1; start_b = cyc;
      end
    end
    cyc++;
    #1;
    chk("model_a", 64'(got_a), 64'(model(HZ_A, DS_A, CS_A, started_a, start_a, cyc)));
    chk("model_b", 64'(got_b), 64'(model(HZ_B, DS_B, CS_B, started_b, start_b, cyc)));
  endtask

  task automatic rst_both();
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  typedef struct {
    bit r;
    bit e;
    bit t;
    int n;
    bit lo;
    bit dn;
  } vec_t;

  vec_t vecs[8];
  int t0, done_cnt, done_at;

  initial begin
    rst = 1'b1; en = 1'b0; lock_trig = 1'b0;

    // Table: {rst, en, lock_trig, cycles held, expected lockout, expected done} of DUT A.
    vecs[0] = '{1, 0, 0,  2, 0, 0};   // reset
    vecs[1] = '{0, 1, 0,  5, 0, 0};   // idle hold
    vecs[2] = '{0, 0, 1, 20, 0, 0};   // trigger gated by en=0
    vecs[3] = '{0, 1, 1,  1, 1, 0};   // trigger -> DENIED
    vecs[4] = '{0, 0, 0, 49, 1, 0};   // last DENIED cycle
    vecs[5] = '{0, 1, 1,  1, 1, 0};   // trigger ignored, first COUNT cycle
    vecs[6] = '{1, 0, 0,  1, 0, 0};   // reset mid-sequence
    vecs[7] = '{0, 0, 0,  3, 0, 0};   // stays idle
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vecs[i].n; j++) step(vecs[i].r, vecs[i].e, vecs[i].t);
      chk("vec_lockout", 64'(lockout_a), 64'(vecs[i].lo));
      chk("vec_done", 64'(done_a), 64'(vecs[i].dn));
      $display("[TB] vec %0d rst=%0d en=%0d trig=%0d x%0d lockout=%0d done=%0d",
               i, vecs[i].r, vecs[i].e, vecs[i].t, vecs[i].n, lockout_a, done_a);
    end
    chk("reset_leds", 64'({l5a, l4a, l3a, l2a, l1a, l0a}), 64'(BLANK6));

    // Full sequence with a mid-COUNT en drop and trigger re-pulse.
    rst_both();
    t0 = cyc; done_cnt = 0; done_at = -1;
    for (int off = 1; off <= 612; off++) begin
      if (off == 1) step(0, 1, 1);
      else if (off == 201) step(0, 0, 1);
      else step(0, 1, 0);
      if (done_a) begin done_cnt++; done_at = off; end
      case (off)
        1, 50:   chk("denied_a", 64'({l5a, l4a, l3a, l2a, l1a, l0a}), 64'(DENIED6));
        51:      chk("count55_full", 64'({l5a, l4a, l3a, l2a, l1a, l0a}),
                     64'({{4{7'h7F}}, 7'h12, 7'h12}));
        60:      chk("count55_end", 64'({l1a, l0a}), 64'({7'h12, 7'h12}));
        61, 70:  chk("count54", 64'({l1a, l0a}), 64'({7'h12, 7'h19}));
        601, 610: chk("count00", 64'({l1a, l0a}), 64'({7'h40, 7'h40}));
        611:     chk("done_pulse", 64'({lockout_a, done_a}), 64'(2'b11));
        612:     chk("idle_after", 64'({lockout_a, done_a}), 64'(2'b00));
        default: ;
      endcase
      case (off)
        10:      chk("b_denied", 64'({l5b, l4b, l3b, l2b, l1b, l0b}), 64'(DENIED6));
        11, 20:  chk("b_count00", 64'({lockout_b, l1b, l0b}), 64'({1'b1, 7'h40, 7'h40}));
        21:      chk("b_done", 64'(done_b), 64'(1));
        22:      chk("b_idle", 64'(lockout_b), 64'(0));
        default: ;
      endcase
    end
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("done_at", 64'(done_at), 64'(611));
    $display("[TB] full sequence: done at cycle %0d, %0d pulse(s)", done_at, done_cnt);

    // Reset in the middle of COUNT: no done pulse afterwards.
    rst_both();
    t0 = cyc; done_cnt = 0;
    for (int off = 1; off <= 700; off++) begin
      if (off == 1) step(0, 1, 1);
      else if (off == 301) step(1, 1, 0);
      else step(0, 1, 0);
      if (done_a) done_cnt++;
      if (off == 300) chk("pre_rst_active", 64'(lockout_a), 64'(1));
      if (off == 301) chk("rst_idle", 64'({lockout_a, done_a, l5a, l4a, l3a, l2a, l1a, l0a}),
                          64'({2'b00, BLANK6}));
    end
    chk("rst_no_done", 64'(done_cnt), 64'(0));
    $display("[TB] mid-count reset: %0d done pulse(s)", done_cnt);

    // Trigger held high through DONE: one IDLE cycle, then DENIED again.
    rst_both();
    t0 = cyc;
    for (int off = 1; off <= 620; off++) begin
      step(0, 1, 1);
      case (off)
        611: chk("held_done", 64'(done_a), 64'(1));
        612: chk("held_idle", 64'({lockout_a, done_a}), 64'(2'b00));
        613: chk("held_redeny", 64'({lockout_a, l5a, l4a, l3a, l2a, l1a, l0a}),
                 64'({1'b1, DENIED6}));
        default: ;
      endcase
    end
    $display("[TB] held trigger: re-entered DENIED, lockout=%0d", lockout_a);

    // Random stimulus against the model.
    rst_both();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end
    $display("[TB] random: 3000 cycles applied");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
